// File: rtl/div_wrapper.sv
// Board-level sequential divider.
// The switches supply the operand bytes, and the buttons load them and start a division.
// A 2*DW-bit dividend is divided by a DW-bit divisor with a restoring
// shift-subtract datapath that takes one quotient bit per cycle.
// The LEDs show either the quotient or the zero-extended remainder.
module div_wrapper #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW:0]     sw,
    input  logic [2:0]      btn,
    output logic [2*DW-1:0] led,
    output logic            busy,
    output logic            err
);

    localparam int CW = $clog2(2 * DW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        btn_q;
    logic [2:0]        rise;
    logic [2*DW-1:0]   dividend, dividend_nxt;
    logic [DW-1:0]     divisor;
    logic [2*DW-1:0]   quotient;
    logic [DW-1:0]     remainder;
    logic [2*DW-1:0]   dvd_w;
    logic [DW-1:0]     dvs_w;
    logic [DW-1:0]     rem_w;
    logic [CW-1:0]     cnt;
    logic [DW:0]       t;
    logic [DW:0]       diff;
    logic              ge;
    logic              last;
    logic              start_ok;
    logic              start_zero;

    assign rise       = btn & ~btn_q;
    assign start_ok   = (state == IDLE) && rise[2] && (sw[DW-1:0] != '0);
    assign start_zero = (state == IDLE) && rise[2] && (sw[DW-1:0] == '0);

    // The partial remainder is one bit wider so that values up to 2*dvs-1 compare correctly.
    assign t    = {rem_w, dvd_w[2*DW-1]};
    assign diff = t - {1'b0, dvs_w};
    assign ge   = (t >= {1'b0, dvs_w});
    assign last = (cnt == CW'(2 * DW - 1));

    // Dividend after this cycle's byte loads; a valid start latches this value.
    always_comb begin
        dividend_nxt = dividend;
        if (rise[0]) dividend_nxt[DW-1:0]    = sw[DW-1:0];
        if (rise[1]) dividend_nxt[2*DW-1:DW] = sw[DW-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. A start received while not in IDLE is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (last)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. The LED mux follows sw[DW] combinationally.
    always_comb begin
        busy = (state != IDLE);
        led  = sw[DW] ? {{DW{1'b0}}, remainder} : quotient;
    end

    // Button edge detect, operand bytes, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q     <= '0;
            dividend  <= '0;
            divisor   <= '0;
            quotient  <= '0;
            remainder <= '0;
            dvd_w     <= '0;
            dvs_w     <= '0;
            rem_w     <= '0;
            cnt       <= '0;
            err       <= 1'b0;
        end else begin
            btn_q    <= btn;
            dividend <= dividend_nxt;
            if (start_ok) begin
                divisor <= sw[DW-1:0];
                dvd_w   <= dividend_nxt;
                dvs_w   <= sw[DW-1:0];
                rem_w   <= '0;
                cnt     <= '0;
                err     <= 1'b0;
            end else if (start_zero) begin
                // A divide by zero reports all-ones. It passes the low byte of the
                // dividend through unchanged and ignores bytes loaded in this cycle.
                divisor   <= '0;
                err       <= 1'b1;
                quotient  <= '1;
                remainder <= dividend[DW-1:0];
            end
            if (state == RUN) begin
                rem_w <= ge ? diff[DW-1:0] : t[DW-1:0];
                dvd_w <= {dvd_w[2*DW-2:0], ge};
                cnt   <= cnt + 1'b1;
            end
            if (state == DONE) begin
                quotient  <= dvd_w;
                remainder <= rem_w;
            end
        end
    end

endmodule

// File: doc/div_wrapper.md
Name: div_wrapper

Overview:
- Board-level sequential divider: the inverse of the team's multiplier/compare wrapper.
- Operands are entered byte-wise from switches under button control.
- A 16-bit dividend is divided by an 8-bit divisor using a multi-cycle restoring shift-subtract datapath.
- Quotient or remainder is shown on LEDs, with busy and divide-by-zero status.

Parameters:
DW, 8, operand byte width; dividend is 2*DW bits, divisor DW bits, iteration count 2*DW

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
sw  input  9  sw[7:0] operand byte; sw[8] display select (0 quotient, 1 remainder)
btn  input  3  btn[0] load dividend low byte, btn[1] load dividend high byte, btn[2] load divisor and start; debounced upstream, level
led  output  16  sw[8]=0: quotient[15:0]; sw[8]=1: {8'h00, remainder[7:0]}
busy  output  1  division in progress
err  output  1  last start had divisor == 0

Behaviour:
- Reset (rst sampled high):
  - dividend, divisor, quotient, remainder and working registers <= 0.
  - btn edge-detect registers <= 0; state <= IDLE.
  - Outputs: busy=0, err=0, led=0.
- Button edge detect: rise[i] = btn[i] & ~btn_q[i], with btn_q registered each cycle. Only one-cycle rises act; held buttons do nothing further.
- rise[0]: dividend[7:0] <= sw[7:0]. rise[1]: dividend[15:8] <= sw[7:0]. Both are accepted in any state; they never disturb a running division.
- rise[0] and rise[1] in the same cycle: both bytes load sw[7:0].
- FSM states: IDLE, RUN, DONE.
- IDLE, rise[2], sw[7:0] != 0:
  - divisor <= sw[7:0].
  - Working copies: dvd_w <= dividend (the value after any same-cycle byte load), dvs_w <= sw[7:0], rem_w <= 0, cnt <= 0.
  - err <= 0; state <= RUN.
- IDLE, rise[2], sw[7:0] == 0:
  - divisor <= 0, err <= 1.
  - quotient <= 16'hFFFF; remainder <= dividend[7:0] (current registered dividend). Dividend bytes loaded in the same cycle are not used.
  - state stays IDLE; busy never asserts.
- RUN, each cycle (restoring algorithm):
  - t = {rem_w[DW-1:0], dvd_w[2DW-1]} (DW+1 bits); dvd_w shifts left by 1.
  - If t >= dvs_w: rem_w <= t - dvs_w and a 1 is shifted into the dvd_w LSB; else rem_w <= t and a 0 is shifted in.
  - cnt increments. When cnt == 2*DW-1, state <= DONE.
- DONE, one cycle: quotient <= dvd_w, remainder <= rem_w[DW-1:0], state <= IDLE.
- busy = (state != IDLE), registered-equivalent: high the cycle after rise[2] is sampled, for exactly 2*DW+1 = 17 cycles. quotient and remainder update on the edge where busy falls.
- quotient and remainder hold until the next completed or errored start. led is combinational from sw[8] and these registers, so sw[8] toggling takes effect immediately.
- rise[2] while busy: ignored entirely; the divisor register is not updated and no restart occurs.
- rst high mid-RUN: abort, return to IDLE next cycle, all outputs 0.
- Width rules:
  - quotient is the full 2*DW bits; no overflow is possible.
  - remainder is always < divisor.
  - Comparison uses DW+1 bits so that t up to 2*dvs-1 is handled.

Test Plan:
- Dividend 0x03E8 (1000) loaded via btn[1]=0x03, btn[0]=0xE8; btn[2] with sw=0x07 -> busy high 17 cycles; led=0x008E (142); with sw[8]=1, led=0x0006.
- Dividend 0xFFFF, divisor 0x01 -> quotient 0xFFFF, remainder 0x00. Dividend 0xFFFF, divisor 0xFF -> quotient 0x0101, remainder 0x00.
- Dividend 0x0005, divisor 0x09 -> quotient 0x0000, remainder 0x05, err=0.
- Divisor 0x00 with dividend 0x1234 -> err=1 next cycle, busy stays 0, quotient 0xFFFF, remainder 0x34. A following valid start clears err.
- During RUN of 1000/7: pulse btn[2] with sw=0x03 and btn[0] with sw=0x11 -> result still 142 r 6. Then restart -> 0x0311/0x03 = 0x0105 r 2.
- Hold btn[2] high 40 cycles -> exactly one division. Assert rst at cycle 8 of RUN -> busy=0, led=0, err=0 next cycle.
